decoder_queue: RTL and testbench

- Parametrised successor to the single-shot decoder. Decodes RV32I plus optional M, A and Zicsr/system instructions into the shared `instructions` struct.
- Buffers decoded entries in a DEPTH-entry FIFO, with valid/ready handshakes on both sides, so fetch and execute are decoupled.
- Flags illegal or disabled encodings instead of silently zeroing them.
- Sits between the fetch unit and the register-read/execute stage.

---
 rtl/decoder_queue_pkg.sv | 39 +++
 rtl/decoder_queue_decode_comb.sv | 177 +++++++++++++++++
 rtl/decoder_queue.sv | 86 ++++++++
 tb/tb_decoder_queue.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_queue_pkg.sv
// Shared types for the decode/queue slice.
// Holds the `instructions` entry format produced by decode_comb and buffered
// by decoder_queue, plus the RV32 major-opcode constants.
package decoder_queue_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_AMO    = 7'b0101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // One decoded instruction. For csrr*i the rs1 field carries the 5-bit
  // uimm; the queue reports rs1=0 on its out_rs1 port for those forms.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic        writes_to_reg;
    logic        illegal;
    logic lui, auipc, jal, jalr;
    logic beq, bne, blt, bge, bltu, bgeu;
    logic lb, lh, lw, lbu, lhu;
    logic sb, sh, sw;
    logic addi, slti, sltiu, xori, ori, andi, slli, srli, srai;
    logic add, sub, sll, slt, sltu, xor_op, srl, sra, or_op, and_op;
    logic mul, mulh, mulhsu, mulhu, div, divu, rem, remu;
    logic lr_w, sc_w, amoswap_w, amoadd_w, amoxor_w, amoand_w;
    logic amoor_w, amomin_w, amomax_w, amominu_w, amomaxu_w, is_amo;
    logic csrrw, csrrs, csrrc, csrrwi, csrrsi, csrrci;
    logic ecall, ebreak, mret, wfi;
  } instructions;

endpackage

// File: rtl/decoder_queue_decode_comb.sv
// decode_comb: purely combinational RV32I(+M/A/Zicsr) decoder.
// Ports: raw (instruction word), pc (its address) -> dec (decoded entry).
// Unknown or disabled encodings produce an entry with only pc and illegal set.
module decode_comb
  import decoder_queue_pkg::*;
#(
  parameter bit ENABLE_M     = 1'b1,
  parameter bit ENABLE_A     = 1'b1,
  parameter bit ENABLE_ZICSR = 1'b1
) (
  input  logic [31:0] raw,
  input  logic [31:0] pc,
  output instructions dec
);

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        ok, use_rd, use_rs1, use_rs2;

  assign opc   = raw[6:0];
  assign f3    = raw[14:12];
  assign f7    = raw[31:25];
  assign imm_i = {{20{raw[31]}}, raw[31:20]};
  assign imm_s = {{20{raw[31]}}, raw[31:25], raw[11:7]};
  assign imm_b = {{19{raw[31]}}, raw[31], raw[7], raw[30:25], raw[11:8], 1'b0};
  assign imm_u = {raw[31:12], 12'b0};
  assign imm_j = {{11{raw[31]}}, raw[31], raw[19:12], raw[20], raw[30:21], 1'b0};

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred; blocking '=' is correct in
  // combinational blocks because later statements must see earlier results.
  always_comb begin
    dec     = '0;
    ok      = 1'b1;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      OP_LUI:   begin dec.lui   = 1'b1; dec.imm = imm_u; use_rd = 1'b1; end
      OP_AUIPC: begin dec.auipc = 1'b1; dec.imm = imm_u; use_rd = 1'b1; end
      OP_JAL:   begin dec.jal   = 1'b1; dec.imm = imm_j; use_rd = 1'b1; end
      OP_JALR: begin
        dec.jalr = 1'b1; ok = (f3 == 3'b000);
        dec.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
      end
      OP_BRANCH: begin
        dec.imm = imm_b; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'b000:  dec.beq  = 1'b1;
          3'b001:  dec.bne  = 1'b1;
          3'b100:  dec.blt  = 1'b1;
          3'b101:  dec.bge  = 1'b1;
          3'b110:  dec.bltu = 1'b1;
          3'b111:  dec.bgeu = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_LOAD: begin
        dec.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
        case (f3)
          3'b000:  dec.lb  = 1'b1;
          3'b001:  dec.lh  = 1'b1;
          3'b010:  dec.lw  = 1'b1;
          3'b100:  dec.lbu = 1'b1;
          3'b101:  dec.lhu = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_STORE: begin
        dec.imm = imm_s; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (f3)
          3'b000:  dec.sb = 1'b1;
          3'b001:  dec.sh = 1'b1;
          3'b010:  dec.sw = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      OP_IMM: begin
        dec.imm = imm_i; use_rd = 1'b1; use_rs1 = 1'b1;
        case (f3)
          3'b000:  dec.addi  = 1'b1;
          3'b010:  dec.slti  = 1'b1;
          3'b011:  dec.sltiu = 1'b1;
          3'b100:  dec.xori  = 1'b1;
          3'b110:  dec.ori   = 1'b1;
          3'b111:  dec.andi  = 1'b1;
          3'b001:  begin dec.slli = 1'b1; ok = (f7 == 7'b0000000); end
          default: begin // 3'b101: shamt forms distinguished by funct7
            dec.srli = (f7 == 7'b0000000);
            dec.srai = (f7 == 7'b0100000);
            ok       = dec.srli | dec.srai;
          end
        endcase
      end
      OP_REG: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case ({f7, f3})
          10'b0000000_000: dec.add    = 1'b1;
          10'b0100000_000: dec.sub    = 1'b1;
          10'b0000000_001: dec.sll    = 1'b1;
          10'b0000000_010: dec.slt    = 1'b1;
          10'b0000000_011: dec.sltu   = 1'b1;
          10'b0000000_100: dec.xor_op = 1'b1;
          10'b0000000_101: dec.srl    = 1'b1;
          10'b0100000_101: dec.sra    = 1'b1;
          10'b0000000_110: dec.or_op  = 1'b1;
          10'b0000000_111: dec.and_op = 1'b1;
          10'b0000001_000: begin dec.mul    = 1'b1; ok = ENABLE_M; end
          10'b0000001_001: begin dec.mulh   = 1'b1; ok = ENABLE_M; end
          10'b0000001_010: begin dec.mulhsu = 1'b1; ok = ENABLE_M; end
          10'b0000001_011: begin dec.mulhu  = 1'b1; ok = ENABLE_M; end
          10'b0000001_100: begin dec.div    = 1'b1; ok = ENABLE_M; end
          10'b0000001_101: begin dec.divu   = 1'b1; ok = ENABLE_M; end
          10'b0000001_110: begin dec.rem    = 1'b1; ok = ENABLE_M; end
          10'b0000001_111: begin dec.remu   = 1'b1; ok = ENABLE_M; end
          default:         ok = 1'b0;
        endcase
      end
      OP_AMO: begin
        dec.is_amo = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case (raw[31:27])
          5'b00010: begin dec.lr_w = 1'b1; use_rs2 = 1'b0; end
          5'b00011: dec.sc_w      = 1'b1;
          5'b00001: dec.amoswap_w = 1'b1;
          5'b00000: dec.amoadd_w  = 1'b1;
          5'b00100: dec.amoxor_w  = 1'b1;
          5'b01100: dec.amoand_w  = 1'b1;
          5'b01000: dec.amoor_w   = 1'b1;
          5'b10000: dec.amomin_w  = 1'b1;
          5'b10100: dec.amomax_w  = 1'b1;
          5'b11000: dec.amominu_w = 1'b1;
          5'b11100: dec.amomaxu_w = 1'b1;
          default:  ok = 1'b0;
        endcase
        ok = ok && (f3 == 3'b010) && ENABLE_A;
      end
      OP_SYSTEM: begin
        dec.imm = {20'b0, raw[31:20]};
        use_rd = (f3 != 3'b000); use_rs1 = (f3 != 3'b000);
        case (f3)
          3'b000: begin
            // Privileged forms require zero rd/rs1 fields.
            dec.ecall  = (raw[31:20] == 12'h000);
            dec.ebreak = (raw[31:20] == 12'h001);
            dec.mret   = (raw[31:20] == 12'h302);
            dec.wfi    = (raw[31:20] == 12'h105);
            ok = (dec.ecall | dec.ebreak | dec.mret | dec.wfi) && (raw[19:7] == 13'd0);
          end
          3'b001:  dec.csrrw  = 1'b1;
          3'b010:  dec.csrrs  = 1'b1;
          3'b011:  dec.csrrc  = 1'b1;
          3'b101:  dec.csrrwi = 1'b1;
          3'b110:  dec.csrrsi = 1'b1;
          3'b111:  dec.csrrci = 1'b1;
          default: ok = 1'b0;
        endcase
        ok = ok && ENABLE_ZICSR;
      end
      default: ok = 1'b0;
    endcase

    dec.rd  = use_rd  ? raw[11:7]  : 5'd0;
    dec.rs1 = use_rs1 ? raw[19:15] : 5'd0;
    dec.rs2 = use_rs2 ? raw[24:20] : 5'd0;
    // Formats without rd (branch, store, ecall/ebreak/mret/wfi) never set use_rd.
    dec.writes_to_reg = use_rd && (raw[11:7] != 5'd0);
    dec.pc = pc;

    if (!ok) begin
      dec         = '0;
      dec.pc      = pc;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decoder_queue.sv
// decoder_queue: decodes fetched instructions and buffers them in a
// DEPTH-entry FIFO between fetch and register-read/execute.
// Ports: clk, rst (async active-high), flush (sync discard of all entries);
// fetch side in_valid/in_ready/in_pc/in_instr; consumer side
// out_valid/out_ready/out_instr/out_rs1/out_rs2; count = occupied entries.
module decoder_queue
  import decoder_queue_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter bit ENABLE_M     = 1'b1,
  parameter bit ENABLE_A     = 1'b1,
  parameter bit ENABLE_ZICSR = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_pc,
  input  logic [31:0]            in_instr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output instructions            out_instr,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  instructions      mem [DEPTH];
  instructions      dec;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  decode_comb #(
    .ENABLE_M     (ENABLE_M),
    .ENABLE_A     (ENABLE_A),
    .ENABLE_ZICSR (ENABLE_ZICSR)
  ) u_decode (
    .raw (in_instr),
    .pc  (in_pc),
    .dec (dec)
  );

  // No bypass: a full queue refuses input even while the head is popped.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // NOTE: sequential state uses non-blocking '<=' so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage has no reset; occupancy is tracked by count alone,
  // so stale contents are never observed as valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign out_instr = mem[rd_ptr];
  // csrr*i keep their uimm in the rs1 field; no register is read for them.
  assign out_rs1 = (out_instr.csrrwi | out_instr.csrrsi | out_instr.csrrci) ? 5'd0 : out_instr.rs1;
  assign out_rs2 = out_instr.rs2;

endmodule

// File: tb/tb_decoder_queue.sv
// Directed self-checking bench for decoder_queue. A second instance with all
// optional extensions disabled shares the same stimulus.
module tb_decoder_queue;
  import decoder_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_instr;
  logic        in_ready, out_valid, in_ready_n, out_valid_n;
  instructions out_instr, out_instr_n;
  logic [4:0]  out_rs1, out_rs2, out_rs1_n, out_rs2_n;
  logic [1:0]  count, count_n;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  decoder_queue #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .count(count)
  );

  decoder_queue #(.DEPTH(2), .ENABLE_M(1'b0), .ENABLE_A(1'b0), .ENABLE_ZICSR(1'b0)) dut_noext (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_n), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid_n), .out_ready(out_ready), .out_instr(out_instr_n),
    .out_rs1(out_rs1_n), .out_rs2(out_rs2_n), .count(count_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ins(input string tag, input instructions obs, input instructions exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pop_head();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  function automatic instructions illegal_entry(input logic [31:0] pc);
    instructions e;
    e = '0;
    e.pc = pc;
    e.illegal = 1'b1;
    return e;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", count, 0);
    tick(); tick();
    rst = 1'b0;

    // addi x1,x0,5
    push(32'h00500093, 32'h100);
    check("addi_out_valid", out_valid, 1);
    check("addi_flag", out_instr.addi, 1);
    check("addi_rd", out_instr.rd, 1);
    check("addi_rs1", out_rs1, 0);
    check("addi_imm", out_instr.imm, 5);
    check("addi_pc", out_instr.pc, 32'h100);
    check("addi_wtr", out_instr.writes_to_reg, 1);
    check("addi_illegal", out_instr.illegal, 0);
    check("addi_count", count, 1);
    pop_head();
    check("addi_popped_valid", out_valid, 0);

    // beq x1,x2,-4
    push(32'hFE208EE3, 32'h104);
    check("beq_flag", out_instr.beq, 1);
    check("beq_imm", out_instr.imm, 32'hFFFFFFFC);
    check("beq_rs1", out_rs1, 1);
    check("beq_rs2", out_rs2, 2);
    check("beq_rd", out_instr.rd, 0);
    check("beq_wtr", out_instr.writes_to_reg, 0);
    pop_head();

    // mul x3,x1,x2
    push(32'h022081B3, 32'h108);
    check("mul_flag", out_instr.mul, 1);
    check("mul_rd", out_instr.rd, 3);
    check("mul_illegal", out_instr.illegal, 0);
    check("mul_wtr", out_instr.writes_to_reg, 1);
    check_ins("mul_noext_entry", out_instr_n, illegal_entry(32'h108));
    check("mul_noext_rs1", out_rs1_n, 0);
    pop_head();

    // lr.w x5,(x6)
    push(32'h100322AF, 32'h10C);
    check("lrw_flag", out_instr.lr_w, 1);
    check("lrw_is_amo", out_instr.is_amo, 1);
    check("lrw_rs1", out_rs1, 6);
    check("lrw_rs2", out_rs2, 0);
    check("lrw_rd", out_instr.rd, 5);
    check("lrw_imm", out_instr.imm, 0);
    check_ins("lrw_noext_entry", out_instr_n, illegal_entry(32'h10C));
    pop_head();

    // lui x7,0x12345
    push(32'h123453B7, 32'h110);
    check("lui_flag", out_instr.lui, 1);
    check("lui_imm", out_instr.imm, 32'h12345000);
    check("lui_rd", out_instr.rd, 7);
    check("lui_rs1", out_rs1, 0);
    check("lui_noext_illegal", out_instr_n.illegal, 0);
    pop_head();

    // csrrsi x8, 0x300, 5
    push(32'h3002E473, 32'h114);
    check("csrrsi_flag", out_instr.csrrsi, 1);
    check("csrrsi_imm", out_instr.imm, 32'h300);
    check("csrrsi_out_rs1", out_rs1, 0);
    check("csrrsi_uimm", out_instr.rs1, 5);
    check("csrrsi_rd", out_instr.rd, 8);
    check("csrrsi_wtr", out_instr.writes_to_reg, 1);
    check_ins("csrrsi_noext_entry", out_instr_n, illegal_entry(32'h114));
    pop_head();

    // fence: opcode not decoded here -> illegal, still queued with its pc
    push(32'h0000000F, 32'h118);
    check("fence_valid", out_valid, 1);
    check_ins("fence_entry", out_instr, illegal_entry(32'h118));
    pop_head();

    // Fill a DEPTH=2 queue with three back-to-back requests.
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h200;
    tick();
    check("fill1_count", count, 1);
    check("fill1_in_ready", in_ready, 1);
    in_instr = 32'h00600113; in_pc = 32'h204;
    tick();
    check("fill2_count", count, 2);
    check("fill2_in_ready", in_ready, 0);
    in_instr = 32'h00700193; in_pc = 32'h208;
    tick();
    check("fill3_held_count", count, 2);
    check("fill3_head_imm", out_instr.imm, 5);
    out_ready = 1'b1;
    #1;
    check("full_no_bypass", in_ready, 0);
    tick();
    check("drain1_count", count, 1);
    check("drain1_head_imm", out_instr.imm, 6);
    tick();
    check("drain2_pushpop_count", count, 1);
    check("drain2_head_imm", out_instr.imm, 7);
    check("drain2_head_pc", out_instr.pc, 32'h208);
    in_valid = 1'b0;
    tick();
    check("drain3_count", count, 0);
    check("drain3_out_valid", out_valid, 0);
    tick();
    check("drain4_count", count, 0);
    out_ready = 1'b0;

    // Flush with one entry and a pushable input in the same cycle.
    push(32'h00500093, 32'h300);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00600113; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check("flush1_count", count, 0);
    check("flush1_out_valid", out_valid, 0);
    tick();
    check("flush1_dropped", count, 0);

    // Flush a full queue.
    push(32'h00500093, 32'h310);
    push(32'h00600113, 32'h314);
    check("flush2_pre_count", count, 2);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00700193;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_count", count, 0);
    check("flush2_out_valid", out_valid, 0);
    check("flush2_in_ready", in_ready, 1);

    // Queue works again after flush; then reset asynchronously mid-cycle.
    push(32'h123453B7, 32'h320);
    check("postflush_imm", out_instr.imm, 32'h12345000);
    check("postflush_pc", out_instr.pc, 32'h320);
    check("prereset_valid", out_valid, 1);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_count", count, 0);
    check("async_rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
